// File: rtl/jtsdram_sched.sv
// Lock-step pass scheduler for the SDRAM bank testers: launches passes, cycles the access mode,
// and folds tester bad flags into pass/error counters. Optional watchdog: define JTSDRAM_WDOG_EN.
module jtsdram_sched #(
    parameter int BANKS  = 4,
    parameter int TOUT_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [BANKS-1:0] en_mask,
    input  logic [BANKS-1:0] done,
    input  logic [BANKS-1:0] bad,
    output logic [BANKS-1:0] start,
    output logic             we,
    output logic             slow,
    output logic             busy,
    output logic [15:0]      pass_cnt,
    output logic [7:0]       err_cnt,
    output logic [BANKS-1:0] bad_seen,
    output logic             tout
);

    typedef enum logic [2:0] {IDLE, LAUNCH, SETTLE, RUN, CHECK} state_t;

    state_t           state_q, state_d;
    logic [BANKS-1:0] mask_q, mask_d;
    logic [BANKS-1:0] start_q, start_d;
    logic [BANKS-1:0] seen_q, seen_d;
    logic [1:0]       mi_q, mi_d;
    logic [15:0]      pass_q, pass_d;
    logic [7:0]       err_q, err_d;
    logic             go_launch;
    logic             all_done;
    logic             new_bad;
    logic             wd_fire;
    logic             wd_err;

    // Banks outside the latched mask count as finished so a dead, disabled tester cannot stall a pass.
    assign all_done = &(done | ~mask_q);
    assign new_bad  = |(bad & mask_q & ~seen_q);

`ifdef JTSDRAM_WDOG_EN
    logic [TOUT_W-1:0] wd_q, wd_d;
    logic              tout_q, tout_d;
    logic              wdf_q, wdf_d;

    assign wd_fire = (state_q == RUN) && !all_done && (&wd_q);

    always_comb begin
        wd_d   = wd_q;
        tout_d = tout_q;
        wdf_d  = wdf_q;
        if (state_q == LAUNCH) begin
            wd_d  = '0;
            wdf_d = 1'b0;
        end else if (state_q == RUN) begin
            if (wd_fire) begin
                tout_d = 1'b1;
                wdf_d  = 1'b1;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q   <= '0;
            tout_q <= 1'b0;
            wdf_q  <= 1'b0;
        end else begin
            wd_q   <= wd_d;
            tout_q <= tout_d;
            wdf_q  <= wdf_d;
        end
    end

    assign wd_err = wdf_q;
    assign tout   = tout_q;
`else
    logic [TOUT_W-1:0] wdog_unused;
    assign wdog_unused = '0;
    assign wd_fire     = 1'b0;
    assign wd_err      = 1'b0;
    assign tout        = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        start_d   = '0;
        seen_d    = seen_q;
        mi_d      = mi_q;
        pass_d    = pass_q;
        err_d     = err_q;
        go_launch = 1'b0;
        case (state_q)
            IDLE:    if (run && (|en_mask)) go_launch = 1'b1;
            LAUNCH:  state_d = SETTLE;
            // Testers still present the previous pass's done here, so it is not looked at.
            SETTLE:  state_d = RUN;
            RUN:     if (all_done || wd_fire) state_d = CHECK;
            CHECK: begin
                seen_d = seen_q | (bad & mask_q);
                if ((new_bad || wd_err) && (err_q != 8'hFF)) err_d = err_q + 8'd1;
                pass_d = pass_q + 16'd1;
                mi_d   = mi_q + 2'd1;
                if (run) go_launch = 1'b1;
                else     state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Mask and start are registered together so start in LAUNCH equals the latched mask.
        if (go_launch) begin
            state_d = LAUNCH;
            mask_d  = en_mask;
            start_d = en_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mask_q  <= '0;
            start_q <= '0;
            seen_q  <= '0;
            mi_q    <= 2'd0;
            pass_q  <= 16'd0;
            err_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            start_q <= start_d;
            seen_q  <= seen_d;
            mi_q    <= mi_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
        end
    end

    assign start    = start_q;
    assign we       = mi_q[0];
    assign slow     = mi_q[1];
    assign busy     = (state_q != IDLE);
    assign pass_cnt = pass_q;
    assign err_cnt  = err_q;
    assign bad_seen = seen_q;

endmodule

// File: tb/tb_jtsdram_sched.sv
// Bench for jtsdram_sched: behavioural bank testers, a pass-level reference model,
// a table of hand-computed passes, randomized passes and multi-cycle corner sequences.
module tb_jtsdram_sched;
`ifdef JTSDRAM_WDOG_EN
    localparam int TW = 8;
`else
    localparam int TW = 24;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [3:0] en_mask = 4'h0;
    logic [3:0] done = 4'h0;
    logic [3:0] bad = 4'h0;
    logic [3:0] start;
    logic       we, slow, busy, tout;
    logic [15:0] pass_cnt;
    logic [7:0]  err_cnt;
    logic [3:0]  bad_seen;

    jtsdram_sched #(.BANKS(4), .TOUT_W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .en_mask(en_mask), .done(done), .bad(bad),
        .start(start), .we(we), .slow(slow), .busy(busy), .pass_cnt(pass_cnt),
        .err_cnt(err_cnt), .bad_seen(bad_seen), .tout(tout)
    );

    always #5 clk = ~clk;

    // Behavioural testers: done drops on start, rises 'delay' cycles later unless the bank hangs.
    int         cnt [4] = '{default: 0};
    int         delay = 1;
    logic [3:0] hang = 4'h0;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (start[i]) begin
                done[i] <= 1'b0;
                cnt[i]  <= hang[i] ? 0 : delay;
            end else if (cnt[i] > 0) begin
                cnt[i] <= cnt[i] - 1;
                if (cnt[i] == 1) done[i] <= 1'b1;
            end
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Pass-level reference model.
    int         m_pass = 0;
    int         m_err = 0;
    logic [3:0] m_seen = 4'h0;
    logic       m_tout = 1'b0;

    task automatic model_reset();
        m_pass = 0; m_err = 0; m_seen = 4'h0; m_tout = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] m, input logic [3:0] b, input logic [3:0] hg);
        logic [3:0] nb;
        logic       wd;
        nb = b & m & ~m_seen;
        wd = ((hg & m) != 4'h0);
        m_seen = m_seen | (b & m);
        if ((nb != 4'h0 || wd) && m_err < 255) m_err++;
        if (wd) m_tout = 1'b1;
        m_pass = (m_pass + 1) % 65536;
    endtask

    // One isolated pass: run is raised until LAUNCH, then dropped so the FSM returns to IDLE.
    task automatic do_pass(input logic [3:0] m, input logic [3:0] b, input int dly, input logic [3:0] hg,
                           input logic ew, input logic es, input int ep, input int ee,
                           input logic [3:0] eseen, input logic etout);
        int   n;
        logic stable;
        @(negedge clk);
        en_mask = m; bad = b; delay = dly; hang = hg; run = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!busy && n < 8);
        chk("launch_busy", busy, 1);
        run = 1'b0;
        en_mask = 4'($urandom);
        chk("start_mask", start, m);
        chk("mode", {we, slow}, {ew, es});
        @(negedge clk);
        chk("start_width", start, 0);
        stable = 1'b1;
        n = 0;
        while (busy && n < 2000) begin
            if ({we, slow} !== {ew, es} || start !== 4'h0) stable = 1'b0;
            @(negedge clk);
            n++;
        end
        chk("pass_end", busy, 0);
        chk("mode_stable", stable, 1);
        chk("pass_cnt", pass_cnt, ep);
        chk("err_cnt", err_cnt, ee);
        chk("bad_seen", bad_seen, eseen);
        chk("tout", tout, etout);
    endtask

    typedef struct {
        logic [3:0] m, b, hg;
        int         dly;
        logic       ew, es;
        int         ep, ee;
        logic [3:0] eseen;
    } vec_t;

    vec_t tbl [10];

    initial begin
        logic [3:0] m, hg, bacc;
        logic       flag;
        int         dly, cyc, last, nst, n;

        tbl[0] = '{4'hF, 4'h0, 4'h0, 100, 1'b0, 1'b0, 1, 0, 4'h0};
        tbl[1] = '{4'hF, 4'h0, 4'h0, 100, 1'b1, 1'b0, 2, 0, 4'h0};
        tbl[2] = '{4'hF, 4'h0, 4'h0, 100, 1'b0, 1'b1, 3, 0, 4'h0};
        tbl[3] = '{4'hF, 4'h0, 4'h0, 100, 1'b1, 1'b1, 4, 0, 4'h0};
        tbl[4] = '{4'h5, 4'h0, 4'hA, 5,   1'b0, 1'b0, 5, 0, 4'h0};
        tbl[5] = '{4'h5, 4'h0, 4'hA, 3,   1'b1, 1'b0, 6, 0, 4'h0};
        tbl[6] = '{4'hF, 4'h4, 4'h0, 7,   1'b0, 1'b1, 7, 1, 4'h4};
        tbl[7] = '{4'hF, 4'h4, 4'h0, 7,   1'b1, 1'b1, 8, 1, 4'h4};
        tbl[8] = '{4'hE, 4'h5, 4'h0, 4,   1'b0, 1'b0, 9, 1, 4'h4};
        tbl[9] = '{4'hF, 4'h5, 4'h0, 2,   1'b1, 1'b0, 10, 2, 4'h5};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {busy, start, we, slow, tout}, 0);
        chk("rst_cnt", {pass_cnt, err_cnt, bad_seen}, 0);
        rst_n = 1'b1;

        // Empty mask keeps the scheduler idle
        @(negedge clk);
        run = 1'b1; en_mask = 4'h0;
        flag = 1'b1;
        repeat (5) begin @(negedge clk); if (busy || start != 4'h0) flag = 1'b0; end
        chk("idle_empty_mask", flag, 1);
        run = 1'b0;

        for (int k = 0; k < 10; k++) begin
            model_step(tbl[k].m, tbl[k].b, tbl[k].hg);
            do_pass(tbl[k].m, tbl[k].b, tbl[k].dly, tbl[k].hg, tbl[k].ew, tbl[k].es,
                    tbl[k].ep, tbl[k].ee, tbl[k].eseen, 1'b0);
        end

        // Randomized passes against the model; bad stays sticky like the real testers
        bacc = 4'h5;
        for (int k = 0; k < 24; k++) begin
            logic ew, es;
            m = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 3) == 0) bacc = bacc | 4'(1 << $urandom_range(0, 3));
            hg = 4'($urandom) & ~m;
            dly = $urandom_range(1, 30);
            ew = m_pass[0]; es = m_pass[1];
            model_step(m, bacc, hg);
            do_pass(m, bacc, dly, hg, ew, es, m_pass, m_err, m_seen, m_tout);
        end

        // Back-to-back passes with run held: no idle cycle, mode rotates
        @(negedge clk);
        en_mask = 4'hF; bad = bacc; delay = 2; hang = 4'h0; run = 1'b1;
        last = -1; cyc = 0; nst = 0;
        while (nst < 4 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (start != 4'h0) begin
                chk("b2b_mode", {we, slow}, {m_pass[0], m_pass[1]});
                if (last >= 0) chk("b2b_gap", cyc - last, 5);
                last = cyc;
                model_step(4'hF, bacc, 4'h0);
                nst++;
                if (nst == 4) run = 1'b0;
            end
        end
        chk("b2b_starts", nst, 4);
        n = 0;
        while (busy && n < 200) begin @(negedge clk); n++; end
        chk("b2b_end", busy, 0);
        chk("b2b_pass_cnt", pass_cnt, m_pass);
        chk("b2b_err_cnt", err_cnt, m_err);

        // Asynchronous reset in the middle of RUN
        @(negedge clk);
        en_mask = 4'hF; bad = 4'h0; delay = 50; hang = 4'h0; run = 1'b1;
        repeat (6) @(negedge clk);
        chk("mid_run_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ctrl", {busy, start, we, slow, tout}, 0);
        chk("arst_cnt", {pass_cnt, err_cnt, bad_seen}, 0);
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        model_step(4'hF, 4'h0, 4'h0);
        do_pass(4'hF, 4'h0, 5, 4'h0, 1'b0, 1'b0, 1, 0, 4'h0, 1'b0);

`ifdef JTSDRAM_WDOG_EN
        // Hung enabled bank: watchdog ends the pass, flags tout, counts an error once
        model_step(4'h1, 4'h0, 4'h1);
        do_pass(4'h1, 4'h0, 5, 4'h1, 1'b1, 1'b0, 2, 1, 4'h0, 1'b1);
        model_step(4'hF, 4'h0, 4'h0);
        do_pass(4'hF, 4'h0, 3, 4'h0, 1'b0, 1'b1, 3, 1, 4'h0, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
